// File: rtl/control_unit.sv
// Main-decoder control unit: registered datapath steering word from the major opcode.
// Optional CONTROL_STALL_EN adds a stall input that loads the NOP word as a bubble.
module control_unit #(
    parameter int opwidth   = 3,
    parameter int mcodebits = 3
) (
    input  logic                 clk,
    input  logic                 reset,
`ifdef CONTROL_STALL_EN
    input  logic                 stall,
`endif
    input  logic [mcodebits-1:0] instruction,
    output logic                 branch,
    output logic                 memToReg,
    output logic                 memWrite,
    output logic                 aluSrc,
    output logic                 regWrite,
    output logic [opwidth-1:0]   aluOp
);

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_AND   = 3'b010,
        OP_SHIFT = 3'b011,
        OP_ADDI  = 3'b100,
        OP_LOAD  = 3'b101,
        OP_STORE = 3'b110,
        OP_BEQ   = 3'b111
    } opcode_t;

    logic               illegal;
    logic               bubble;
    opcode_t            opcode;
    logic               nxt_branch;
    logic               nxt_mem_to_reg;
    logic               nxt_mem_write;
    logic               nxt_alu_src;
    logic               nxt_reg_write;
    logic [opwidth-1:0] nxt_alu_op;

    // Any set bit above the 3-bit major opcode marks the instruction illegal.
    generate
        if (mcodebits > 3) begin : g_wide
            assign illegal = |instruction[mcodebits-1:3];
        end else begin : g_narrow
            assign illegal = 1'b0;
        end
    endgenerate

`ifdef CONTROL_STALL_EN
    assign bubble = stall;
`else
    assign bubble = 1'b0;
`endif

    assign opcode = opcode_t'(instruction[2:0]);

    always_comb begin
        nxt_branch     = 1'b0;
        nxt_mem_to_reg = 1'b0;
        nxt_mem_write  = 1'b0;
        nxt_alu_src    = 1'b0;
        nxt_reg_write  = 1'b0;
        nxt_alu_op     = '0;
        if (!illegal && !bubble) begin
            unique case (opcode)
                OP_ADD: begin
                    nxt_reg_write = 1'b1;
                end
                OP_SUB: begin
                    nxt_reg_write  = 1'b1;
                    nxt_alu_op[2:0] = 3'b001;
                end
                OP_AND: begin
                    nxt_reg_write  = 1'b1;
                    nxt_alu_op[2:0] = 3'b010;
                end
                OP_SHIFT: begin
                    nxt_reg_write  = 1'b1;
                    nxt_alu_op[2:0] = 3'b011;
                end
                OP_ADDI: begin
                    nxt_alu_src   = 1'b1;
                    nxt_reg_write = 1'b1;
                end
                OP_LOAD: begin
                    nxt_mem_to_reg = 1'b1;
                    nxt_alu_src    = 1'b1;
                    nxt_reg_write  = 1'b1;
                end
                OP_STORE: begin
                    nxt_mem_write = 1'b1;
                    nxt_alu_src   = 1'b1;
                end
                OP_BEQ: begin
                    nxt_branch      = 1'b1;
                    nxt_alu_op[2:0] = 3'b001;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            branch   <= 1'b0;
            memToReg <= 1'b0;
            memWrite <= 1'b0;
            aluSrc   <= 1'b0;
            regWrite <= 1'b0;
            aluOp    <= '0;
        end else begin
            branch   <= nxt_branch;
            memToReg <= nxt_mem_to_reg;
            memWrite <= nxt_mem_write;
            aluSrc   <= nxt_alu_src;
            regWrite <= nxt_reg_write;
            aluOp    <= nxt_alu_op;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: default instance plus a 4-bit-opcode / 5-bit-aluOp instance,
// checked against a rule-based reference model.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       stall = 1'b0;
    logic [2:0] instr0 = '0;
    logic [3:0] instr1 = '0;

    logic       br0, m2r0, mw0, src0, rw0;
    logic [2:0] alu0;
    logic       br1, m2r1, mw1, src1, rw1;
    logic [4:0] alu1;

    int checks = 0;
    int errors = 0;

`ifdef CONTROL_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    control_unit u0 (
        .clk(clk), .reset(reset),
`ifdef CONTROL_STALL_EN
        .stall(stall),
`endif
        .instruction(instr0),
        .branch(br0), .memToReg(m2r0), .memWrite(mw0),
        .aluSrc(src0), .regWrite(rw0), .aluOp(alu0)
    );

    control_unit #(.opwidth(5), .mcodebits(4)) u1 (
        .clk(clk), .reset(reset),
`ifdef CONTROL_STALL_EN
        .stall(stall),
`endif
        .instruction(instr1),
        .branch(br1), .memToReg(m2r1), .memWrite(mw1),
        .aluSrc(src1), .regWrite(rw1), .aluOp(alu1)
    );

    // Reference word {branch, memToReg, memWrite, aluSrc, regWrite, aluOp[4:0]} from the opcode rules.
    function automatic logic [9:0] model(input int op, input bit nop);
        logic [4:0] alu;
        if (nop) return '0;
        if (op < 4)       alu = 5'(op);
        else if (op == 7) alu = 5'd1;
        else              alu = 5'd0;
        return {op == 7, op == 5, op == 6, (op >= 4 && op <= 6), op <= 5, alu};
    endfunction

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [2:0] i0, input logic [3:0] i1,
                        input logic rst, input logic stl);
        logic [9:0] e0, e1;
        bit         nop;
        instr0 = i0;
        instr1 = i1;
        reset  = rst;
        stall  = stl;
        nop = rst || (STALL_EN && stl);
        e0 = model(int'(i0), nop);
        e1 = model(int'(i1[2:0]), nop || i1[3]);
        @(posedge clk);
        #1;
        check({tag, "/u0"}, {br0, m2r0, mw0, src0, rw0, 2'b00, alu0}, e0);
        check({tag, "/u1"}, {br1, m2r1, mw1, src1, rw1, alu1}, e1);
    endtask

    initial begin
        // Reset held two edges with LOAD on the opcode field.
        step("reset0", 3'b101, 4'b0101, 1'b1, 1'b0);
        step("reset1", 3'b101, 4'b0101, 1'b1, 1'b0);

        // Exhaustive back-to-back sweep.
        for (int op = 0; op < 8; op++)
            step($sformatf("sweep%0d", op), 3'(op), {1'b0, 3'(op)}, 1'b0, 1'b0);

        // Reset arriving mid-stream after a STORE.
        step("store", 3'b110, 4'b0110, 1'b0, 1'b0);
        step("mid_reset", 3'b110, 4'b0110, 1'b1, 1'b0);
        step("after_reset", 3'b111, 4'b0111, 1'b0, 1'b0);

        // Illegal upper bit on the wide instance, and zero-extended aluOp.
        step("illegal", 3'b101, 4'b1101, 1'b0, 1'b0);
        step("legal_load", 3'b101, 4'b0101, 1'b0, 1'b0);
        step("shift_width", 3'b011, 4'b0011, 1'b0, 1'b0);

        // Stall behaviour (no effect when the stall port is not built).
        step("stall_addi", 3'b100, 4'b0100, 1'b0, 1'b1);
        step("addi", 3'b100, 4'b0100, 1'b0, 1'b0);
        step("reset_stall", 3'b100, 4'b0100, 1'b1, 1'b1);

        // Randomised traffic with occasional reset and stall.
        for (int n = 0; n < 300; n++)
            step("random", 3'($urandom_range(7)), 4'($urandom_range(15)),
                 $urandom_range(15) == 0, $urandom_range(7) == 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
